// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and SRAM responder states
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
  typedef enum logic [1:0] {HRESP_OKAY, HRESP_ERROR} hresp_t;
  typedef enum logic [1:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_RSVD} hsize_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} sram_state_t;
endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite bus between one master and the SRAM responder
interface ahb_sram_slave_if;
  logic        HSel;
  logic [31:0] HAddr;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [1:0]  HSize;
  logic [3:0]  HBurst;
  logic [31:0] HWData;
  logic [3:0]  HWStrb;
  logic        HReadyIn;
  logic        HReadyOut;
  logic [1:0]  HResp;
  logic [31:0] HRData;
  modport slave (
    input  HSel, HAddr, HTrans, HWrite, HSize, HBurst, HWData, HWStrb, HReadyIn,
    output HReadyOut, HResp, HRData
  );
  modport master (
    output HSel, HAddr, HTrans, HWrite, HSize, HBurst, HWData, HWStrb, HReadyIn,
    input  HReadyOut, HResp, HRData
  );
endinterface

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: word memory with byte-enabled write port and asynchronous read port
module ahb_sram_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // commit enabled byte lanes of the addressed word
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  ahb_sram_slave_if.slave   bus,
  output logic [7:0]        err_count
);
  localparam int AW = $clog2(DEPTH);
  sram_state_t state, state_n, go;
  logic [AW-1:0] idx;
  logic          wr;
  logic [2:0]    cnt;
  logic [31:0]   offset, rdata;
  logic          ready, take, legal;
  logic          unused;
  assign offset = bus.HAddr - BASE_ADDR;
  assign ready  = !(state == S_WAIT || state == S_ERR1);
  assign take   = bus.HSel & bus.HTrans[1] & bus.HReadyIn & ready;
  assign legal  = offset < 32'(4 * DEPTH) && bus.HSize != HSIZE_RSVD &&
                  !(bus.HSize == HSIZE_WORD && |bus.HAddr[1:0]) &&
                  !(bus.HSize == HSIZE_HALF && bus.HAddr[0]);
  assign unused = ^{bus.HBurst, bus.HTrans[0], offset[31:AW+2], offset[1:0]};
  // next state: wait/error sequences run to completion, otherwise follow the sampled address phase
  always_comb begin
    go      = !take ? S_IDLE : !legal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
    state_n = state == S_WAIT ? (cnt == 3'd1 ? S_DATA : S_WAIT) :
              state == S_ERR1 ? S_ERR2 : go;
  end
  // state, wait counter, captured address phase and error counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      wr        <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      cnt   <= take ? 3'(WAIT_STATES) : state == S_WAIT ? cnt - 3'd1 : cnt;
      if (take) begin
        idx <= offset[AW+1:2];
        wr  <= bus.HWrite;
      end
      if (state_n == S_ERR1 && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  assign bus.HReadyOut = ready;
  assign bus.HResp     = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRData    = state == S_DATA ? rdata : '0;
  ahb_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (state == S_DATA && wr),
    .be    (bus.HWStrb),
    .addr  (idx),
    .wdata (bus.HWData),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of the SRAM responder with zero and two wait states
module tb_ahb_sram_slave;
  import ahb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ec0, ec2;
  int total = 0;
  int bad = 0;
  ahb_sram_slave_if i0();
  ahb_sram_slave_if i2();
  assign i0.HReadyIn = i0.HReadyOut;
  assign i2.HReadyIn = i2.HReadyOut;
  always #5 clk = ~clk;
  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(i0), .err_count(ec0));
  ahb_sram_slave #(.WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(i2), .err_count(ec2));
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic ph0(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w, input logic [1:0] z);
    i0.HSel = s; i0.HTrans = t; i0.HAddr = a; i0.HWrite = w; i0.HSize = z; i0.HBurst = 4'd0;
  endtask
  task automatic ph2(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w, input logic [1:0] z);
    i2.HSel = s; i2.HTrans = t; i2.HAddr = a; i2.HWrite = w; i2.HSize = z; i2.HBurst = 4'd0;
  endtask
  task automatic w0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ph0(1, HTRANS_NONSEQ, a, 1, HSIZE_WORD);
    cyc;
    i0.HWData = d; i0.HWStrb = s;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    cyc;
  endtask
  task automatic r0(input logic [31:0] a, output logic [31:0] d);
    ph0(1, HTRANS_NONSEQ, a, 0, HSIZE_WORD);
    cyc;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    d = i0.HRData;
    cyc;
  endtask
  task automatic test_reset;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    ph2(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    i0.HWData = '0; i0.HWStrb = '0; i2.HWData = '0; i2.HWStrb = '0;
    rst = 1'b1;
    cyc;
    @(negedge clk);
    total++; if (i0.HReadyOut !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", i0.HReadyOut); end
    total++; if (i0.HResp !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", i0.HResp); end
    total++; if (i0.HRData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", i0.HRData); end
    total++; if (ec0 !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", ec0); end
    total++; if (i2.HReadyOut !== 1'b1) begin bad++; $display("FAIL reset_ready2 got=%b exp=1", i2.HReadyOut); end
    rst = 1'b0;
    cyc;
  endtask
  task automatic test_write_read;
    ph0(1, HTRANS_NONSEQ, 32'h10, 1, HSIZE_WORD);
    cyc;
    i0.HWData = 32'hDEAD_BEEF; i0.HWStrb = 4'hF;
    ph0(1, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD);
    cyc;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_data got=%h exp=deadbeef", i0.HRData); end
    total++; if (i0.HResp !== 2'b00) begin bad++; $display("FAIL rw_resp got=%b exp=00", i0.HResp); end
    total++; if (i0.HReadyOut !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b exp=1", i0.HReadyOut); end
    cyc;
  endtask
  task automatic test_strobe;
    w0(32'h20, 32'hFFFF_FFFF, 4'hF);
    ph0(1, HTRANS_NONSEQ, 32'h20, 1, HSIZE_WORD);
    cyc;
    i0.HWData = 32'h1122_3344; i0.HWStrb = 4'b0011;
    ph0(1, HTRANS_NONSEQ, 32'h20, 0, HSIZE_WORD);
    cyc;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HRData !== 32'hFFFF_3344) begin bad++; $display("FAIL strobe_data got=%h exp=ffff3344", i0.HRData); end
    cyc;
  endtask
  task automatic test_error;
    logic [31:0] d;
    ph0(1, HTRANS_NONSEQ, 32'h1000, 0, HSIZE_WORD);
    cyc;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HReadyOut !== 1'b0) begin bad++; $display("FAIL err1_ready got=%b exp=0", i0.HReadyOut); end
    total++; if (i0.HResp !== 2'b01) begin bad++; $display("FAIL err1_resp got=%b exp=01", i0.HResp); end
    total++; if (i0.HRData !== 32'h0) begin bad++; $display("FAIL err1_rdata got=%h exp=0", i0.HRData); end
    cyc;
    @(negedge clk);
    total++; if (i0.HReadyOut !== 1'b1) begin bad++; $display("FAIL err2_ready got=%b exp=1", i0.HReadyOut); end
    total++; if (i0.HResp !== 2'b01) begin bad++; $display("FAIL err2_resp got=%b exp=01", i0.HResp); end
    total++; if (ec0 !== 8'd1) begin bad++; $display("FAIL err_count1 got=%0d exp=1", ec0); end
    cyc;
    @(negedge clk);
    total++; if (i0.HResp !== 2'b00) begin bad++; $display("FAIL err_done_resp got=%b exp=00", i0.HResp); end
    cyc;
    w0(32'h0, 32'hA5A5_A5A5, 4'hF);
    ph0(1, HTRANS_NONSEQ, 32'h2, 1, HSIZE_WORD);
    cyc;
    i0.HWData = 32'h0; i0.HWStrb = 4'hF;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HResp !== 2'b01 || i0.HReadyOut !== 1'b0) begin bad++; $display("FAIL mis_err1 got=%b/%b exp=01/0", i0.HResp, i0.HReadyOut); end
    cyc;
    @(negedge clk);
    total++; if (ec0 !== 8'd2) begin bad++; $display("FAIL err_count2 got=%0d exp=2", ec0); end
    cyc;
    r0(32'h0, d);
    total++; if (d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mis_nowrite got=%h exp=a5a5a5a5", d); end
  endtask
  task automatic test_busy_unsel;
    logic [31:0] d;
    ph0(1, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD);
    cyc;
    ph0(1, HTRANS_BUSY, 32'h10, 1, HSIZE_WORD);
    i0.HWData = 32'h0; i0.HWStrb = 4'hF;
    @(negedge clk);
    total++; if (i0.HRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL burst_beat0 got=%h exp=deadbeef", i0.HRData); end
    cyc;
    ph0(0, HTRANS_NONSEQ, 32'h10, 1, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HReadyOut !== 1'b1 || i0.HResp !== 2'b00) begin bad++; $display("FAIL busy_okay got=%b/%b exp=1/00", i0.HReadyOut, i0.HResp); end
    cyc;
    ph0(1, HTRANS_SEQ, 32'h20, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HReadyOut !== 1'b1 || i0.HResp !== 2'b00 || i0.HRData !== 32'h0) begin bad++; $display("FAIL unsel_okay got=%b/%b/%h exp=1/00/0", i0.HReadyOut, i0.HResp, i0.HRData); end
    cyc;
    ph0(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i0.HRData !== 32'hFFFF_3344) begin bad++; $display("FAIL burst_beat1 got=%h exp=ffff3344", i0.HRData); end
    cyc;
    r0(32'h10, d);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL busy_nowrite got=%h exp=deadbeef", d); end
  endtask
  task automatic test_wait_burst;
    for (int p = 0; p < 2; p++) begin
      ph2(1, HTRANS_NONSEQ, 32'h0, p == 0, HSIZE_WORD);
      cyc;
      for (int k = 0; k < 4; k++) begin
        i2.HWData = 32'hC0DE_0000 | 32'(k); i2.HWStrb = 4'hF;
        if (k < 3) ph2(1, HTRANS_SEQ, 32'(4 * (k + 1)), p == 0, HSIZE_WORD);
        else ph2(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
        for (int w = 0; w < 3; w++) begin
          @(negedge clk);
          total++; if (i2.HReadyOut !== (w == 2)) begin bad++; $display("FAIL ws_ready p=%0d k=%0d w=%0d got=%b", p, k, w, i2.HReadyOut); end
          if (p == 1) begin
            total++; if (i2.HRData !== (w == 2 ? (32'hC0DE_0000 | 32'(k)) : 32'h0)) begin bad++; $display("FAIL ws_rdata k=%0d w=%0d got=%h", k, w, i2.HRData); end
          end
          cyc;
        end
      end
    end
  endtask
  task automatic test_reset_mid_write;
    ph2(1, HTRANS_NONSEQ, 32'h4, 1, HSIZE_WORD);
    cyc;
    i2.HWData = 32'h0; i2.HWStrb = 4'hF;
    ph2(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    @(negedge clk);
    total++; if (i2.HReadyOut !== 1'b0) begin bad++; $display("FAIL rstw_inwait got=%b exp=0", i2.HReadyOut); end
    rst = 1'b1;
    #1;
    total++; if (i2.HReadyOut !== 1'b1 || i2.HResp !== 2'b00 || i2.HRData !== 32'h0) begin bad++; $display("FAIL rstw_async got=%b/%b/%h exp=1/00/0", i2.HReadyOut, i2.HResp, i2.HRData); end
    cyc;
    cyc;
    @(negedge clk);
    total++; if (ec0 !== 8'd0) begin bad++; $display("FAIL rstw_errcnt got=%0d exp=0", ec0); end
    rst = 1'b0;
    cyc;
    ph2(1, HTRANS_NONSEQ, 32'h4, 0, HSIZE_WORD);
    cyc;
    ph2(0, HTRANS_IDLE, 0, 0, HSIZE_WORD);
    cyc;
    cyc;
    @(negedge clk);
    total++; if (i2.HRData !== 32'hC0DE_0001) begin bad++; $display("FAIL rstw_nowrite got=%h exp=c0de0001", i2.HRData); end
    cyc;
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_strobe;
    test_error;
    test_busy_unsel;
    test_wait_burst;
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
